keypad_scanner: RTL
===================

# keypad_scanner

Input-side counterpart of the seven-segment screen driver: scans the Nexys A7 Pmod KYPD 4x4 matrix by driving one column low at a time and reading the active-low rows. It debounces the result and delivers one 4-bit key code per press to the calculator core over a valid/ready handshake. The scanner sits between the board pins and the calculator datapath, in the same way the screen driver sits between the datapath and the display pins.

## Interface
Parameters:
- ScanCycles, 16: clocks each column is held low; must be ≥ 4.
- DebounceScans, 3: consecutive identical full scans needed to accept a press or a release; must be ≥ 1.
- RepeatScans, 32: full scans between auto-repeat emissions; used only under KEYPAD_AUTOREPEAT_EN.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- rows_i  in  4  raw keypad rows, active-low, asynchronous to clk_i.
- cols_o  out  4  column drive, active-low, one-cold.
- key_o  out  calc_pkg::key_t (4)  code of accepted key, stable while key_valid_o is high.
- key_valid_o  out  1  key_o holds an undelivered key.
- key_ready_i  in  1  consumer accepts; a transfer occurs when valid and ready are both high on a clock edge.
- key_dropped_o  out  1  one-cycle pulse: a key was accepted while the previous one was still undelivered.

## Operation
- rows_i passes through a 2-flop synchronizer before any use.
- Column scan:
  - Column c is driven low for ScanCycles clocks, in the order c = 0, 1, 2, 3, then wraps to 0.
  - Synchronized rows are sampled on the last cycle of each column period.
  - A full scan is 4*ScanCycles clocks and ends with the column-3 sample.
- Scan result, evaluated at scan end:
  - NONE: no row is low in any column.
  - SINGLE(k): exactly one (row, column) pair is low.
  - MULTI: more than one pair is low.
- Key map, rows top to bottom, column 0 leftmost: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D. The code is the legend's hex value.
- Debounce FSM, one transition per scan end:
  - IDLE:
    - SINGLE(k): latch candidate k, count=1, go to CONFIRM. If DebounceScans=1, emit immediately and go to HELD.
  - CONFIRM:
    - SINGLE(same k): count+1. When count reaches DebounceScans, emit k and go to HELD.
    - SINGLE(different k): restart with the new candidate, count=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: count=1, go to RELEASE.
    - SINGLE or MULTI: stay.
  - RELEASE:
    - NONE: count+1. When count reaches DebounceScans, go to IDLE.
    - Anything else: go to HELD. No new emission.
- Emit:
  - If key_valid_o is low, or a transfer happens in the same cycle: load key_o and hold key_valid_o high.
  - Otherwise: keep the old key, drop the new one, and pulse key_dropped_o.
- key_valid_o falls on the edge where key_ready_i is high; it stays low unless an emit occurs that same cycle.

## Timing
- Reset values: cols_o=4'b1110, key_o=0, key_valid_o=0, key_dropped_o=0. The FSM is in IDLE with counters at 0.
- Asserting rst_i at any time restarts from the reset state immediately; a pending key is discarded.
- Input latency: a row change is visible at the sample point 2 clocks after it arrives.
- Emit latency: key_valid_o rises on the clock edge following the scan end that completes the accepting count.
- The handshake has zero-cycle acceptance; there is no combinational path from key_ready_i to any output other than through the registers.
- Counter widths:
  - Column-cycle counter: $clog2(ScanCycles) bits.
  - Column index: 2 bits, wrapping.
  - Scan counter: $clog2(max(DebounceScans, RepeatScans)+1) bits, saturating.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - HELD counts scan ends while the result is SINGLE of the held key.
  - Every RepeatScans such scans, the held key is emitted again under the normal emit rules.
  - NONE, MULTI, or a different SINGLE resets the repeat count.
- Undefined: exactly one emission per press; the repeat logic and the RepeatScans usage are absent.

## Structure
- calc_pkg additions:
  - typedef key_t (logic [3:0]).
  - Constants KeypadRows=4 and KeypadCols=4.
  - Function rowcol2key(row, col) returning key_t per the map above.
  - Enum keypad_state_e {IDLE, CONFIRM, HELD, RELEASE}.
- Sub-module: synchronizer, a generic 2-flop synchronizer, WIDTH parameter, async active-high reset to 1s (idle rows).

## Test plan
Directed scenarios, with ScanCycles=4, DebounceScans=3, key_ready_i=1 unless stated:
- Reset: after rst_i deasserts, cols_o sequence is 1110,1101,1011,0111 with 4 cycles each, repeating; key_valid_o stays 0 with rows_i=1111.
- Stable press of "5" (row1 low while col1 is driven) from time 0: key_valid_o pulses once with key_o=4'h5, one cycle after the end of scan 3. No second pulse while held.
- Bounce: "9" present for 2 scans, absent for 1, then present for 3: exactly one emission, occurring after the third consecutive scan.
- MULTI: "1" and "2" both low for 10 scans produces no emission. Then "2" alone produces key_o=4'h2.
- Backpressure: key_ready_i=0; press "A" and release, then press "D". key_o stays 4'hA, and key_dropped_o pulses once at the "D" accept. Raising key_ready_i clears key_valid_o on the next edge.
- Async reset mid-press: rst_i pulsed while in CONFIRM clears all outputs without waiting for a clock edge. With the key still held, the press is then accepted 3 scans after reset release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: keypad key code, matrix size, key map and debounce states.
package calc_pkg;

  typedef logic [3:0] key_t;

  localparam int unsigned KeypadRows = 4;
  localparam int unsigned KeypadCols = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } keypad_state_e;

  // Legend of the Pmod KYPD: rows top to bottom, column 0 leftmost.
  function automatic key_t rowcol2key(input logic [1:0] row, input logic [1:0] col);
    key_t k;
    case ({row, col})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_synchronizer.sv
// Generic 2-flop synchronizer; resets to all ones (idle, active-low rows).
module synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages to settle metastability from the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, per-scan classification, debounce FSM and
// valid/ready key delivery. Optional auto-repeat under KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned ScanCycles    = 16,
  parameter int unsigned DebounceScans = 3,
  parameter int unsigned RepeatScans   = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] rows_i,
  output logic [3:0] cols_o,
  output key_t       key_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic       key_dropped_o
);

  localparam int unsigned CycW     = $clog2(ScanCycles);
  localparam int unsigned MaxScans = (DebounceScans > RepeatScans) ? DebounceScans : RepeatScans;
  localparam int unsigned CntW     = $clog2(MaxScans + 1);
  localparam logic [CycW-1:0] CycLast = CycW'(ScanCycles - 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DebounceScans - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(RepeatScans - 1);
`endif

  logic [KeypadRows-1:0] rows_sync;
  logic [CycW-1:0]       cyc_cnt;
  logic [1:0]            col_idx;
  logic [11:0]           low_mask;
  logic [15:0]           full_mask;
  logic                  sample;
  logic                  scan_end;

  logic [1:0]            n_low;
  key_t                  res_key;
  logic                  res_none;
  logic                  res_single;

  keypad_state_e         state, state_d;
  logic [CntW-1:0]       cnt, cnt_d, cnt_inc;
  key_t                  cand, cand_d;
  logic                  emit;
  key_t                  emit_key;
  logic                  xfer;

  synchronizer #(.WIDTH(KeypadRows)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (rows_i),
    .q     (rows_sync)
  );

  assign sample   = (cyc_cnt == CycLast);
  assign scan_end = sample && (col_idx == 2'd3);
  assign cols_o   = ~(4'b0001 << col_idx);

  // Column timing and capture of the low rows seen under columns 0..2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_cnt  <= '0;
      col_idx  <= '0;
      low_mask <= '0;
    end else if (sample) begin
      cyc_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      case (col_idx)
        2'd0:    low_mask[3:0]  <= ~rows_sync;
        2'd1:    low_mask[7:4]  <= ~rows_sync;
        2'd2:    low_mask[11:8] <= ~rows_sync;
        default: ;
      endcase
    end else begin
      cyc_cnt <= cyc_cnt + CycW'(1);
    end
  end

  // Column 3 is classified straight from the synchronizer so the result is ready at scan end.
  assign full_mask = {~rows_sync, low_mask};

  // Classify the completed scan as NONE, SINGLE(key) or MULTI.
  always_comb begin
    n_low   = '0;
    res_key = '0;
    for (int unsigned c = 0; c < KeypadCols; c++) begin
      for (int unsigned r = 0; r < KeypadRows; r++) begin
        if (full_mask[c*4 + r]) begin
          if (n_low != 2'd2) n_low = n_low + 2'd1;
          res_key = rowcol2key(2'(r), 2'(c));
        end
      end
    end
    res_none   = (n_low == 2'd0);
    res_single = (n_low == 2'd1);
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CntW'(1);

  // Debounce state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cand  <= cand_d;
    end
  end

  // Debounce next-state and emit decision, one step per scan end.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cand_d   = cand;
    emit     = 1'b0;
    emit_key = cand;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (res_single) begin
            cand_d = res_key;
            if (DebounceScans == 1) begin
              emit     = 1'b1;
              emit_key = res_key;
              cnt_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d   = CntW'(1);
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (res_single && res_key == cand) begin
            if (cnt >= DebLast) begin
              emit    = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (res_single) begin
            cand_d = res_key;
            cnt_d  = CntW'(1);
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            cnt_d   = CntW'(1);
            state_d = RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          // The count register doubles as the repeat counter while HELD.
          else if (res_single && res_key == cand) begin
            if (cnt >= RepLast) begin
              emit  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
`endif
        end
        default: begin // RELEASE
          if (res_none) begin
            if (cnt >= DebLast) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
      endcase
    end
  end

  assign xfer = key_valid_o && key_ready_i;

  // Output holding register with drop indication under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_o         <= '0;
      key_valid_o   <= 1'b0;
      key_dropped_o <= 1'b0;
    end else begin
      key_dropped_o <= 1'b0;
      if (emit) begin
        if (!key_valid_o || xfer) begin
          key_o       <= emit_key;
          key_valid_o <= 1'b1;
        end else begin
          key_dropped_o <= 1'b1;
        end
      end else if (xfer) begin
        key_valid_o <= 1'b0;
      end
    end
  end

endmodule
